// File: rtl/parity_frame_pkg.sv
// Shared types and sizes for the parity frame receiver.
package parity_frame_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/frame_shift_reg.sv
// Capture register for the data bits of one frame; the MSB_FIRST parameter
// decides which slot each arriving bit lands in.
module frame_shift_reg
  import parity_frame_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data
);

  logic [IDX_W-1:0] slot;

  // First bit on the wire goes to bit 0 (LSB first) or bit DATA_W-1 (MSB first).
  always_comb begin
    slot = idx;
    if (MSB_FIRST) begin
      slot = IDX_W'(DATA_W - 1) - idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (load) begin
      data[slot] <= bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Receiver for start/4 data/parity/stop frames sampled on sample_en strobes.
// Parity is passed through untouched; only the stop bit is checked.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              sample_en,
  output logic [DATA_W-1:0] data_out,
  output logic              par_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t             state;
  logic [IDX_W-1:0]   bit_cnt;
  logic               par_cap;
  logic [DATA_W-1:0]  shift_data;
  logic               shift_clear;
  logic               shift_load;

  assign shift_clear = sample_en && (state == IDLE) && !serial_in;
  assign shift_load  = sample_en && (state == DATA);

  frame_shift_reg #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (shift_clear),
    .load   (shift_load),
    .idx    (bit_cnt),
    .bit_in (serial_in),
    .data   (shift_data)
  );

  // busy is tracked alongside the state so it stays a plain register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      par_cap     <= 1'b0;
      data_out    <= '0;
      par_out     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (sample_en) begin
        case (state)
          IDLE: begin
            if (!serial_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + IDX_W'(1);
            if (bit_cnt == IDX_W'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_cap <= serial_in;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            // A low stop bit is a framing error, never a fresh start bit.
            if (serial_in) begin
              data_out    <= shift_data;
              par_out     <= par_cap;
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + CNT_W'(1);
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: LSB-first and MSB-first instances share one
// serial line and are compared against a frame-level reference model.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       serial_in = 1'b1;
  logic       sample_en = 1'b0;

  logic [3:0] data_lsb, data_msb;
  logic       par_lsb, par_msb;
  logic       valid_lsb, valid_msb;
  logic       err_lsb, err_msb;
  logic       busy_lsb, busy_msb;
  logic [7:0] cnt_lsb, cnt_msb;

  int checks = 0;
  int errors = 0;

  int valid_seen_lsb = 0;
  int valid_seen_msb = 0;
  int err_seen_lsb   = 0;
  int err_seen_msb   = 0;
  int overlap_seen   = 0;

  logic [3:0] m_data_lsb;
  logic [3:0] m_data_msb;
  logic       m_par;
  int         m_cnt;
  int         m_valid = 0;
  int         m_err   = 0;

  typedef struct {
    logic [6:0] bits;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [3:0] exp_data;
    logic       exp_par;
    logic [7:0] exp_cnt;
  } row_t;

  row_t rows[6];

  parity_frame_rx #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .sample_en   (sample_en),
    .data_out    (data_lsb),
    .par_out     (par_lsb),
    .frame_valid (valid_lsb),
    .frame_err   (err_lsb),
    .busy        (busy_lsb),
    .frame_cnt   (cnt_lsb)
  );

  parity_frame_rx #(.MSB_FIRST(1'b1)) dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .sample_en   (sample_en),
    .data_out    (data_msb),
    .par_out     (par_msb),
    .frame_valid (valid_msb),
    .frame_err   (err_msb),
    .busy        (busy_msb),
    .frame_cnt   (cnt_msb)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse held for two cycles counts twice and shows up.
  always @(negedge clk) begin
    if (valid_lsb) valid_seen_lsb++;
    if (valid_msb) valid_seen_msb++;
    if (err_lsb)   err_seen_lsb++;
    if (err_msb)   err_seen_msb++;
    if ((valid_lsb && err_lsb) || (valid_msb && err_msb)) overlap_seen++;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] assemble(input logic [3:0] s, input bit msb);
    int v = 0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) v += msb ? (8 >> i) : (1 << i);
    end
    return 4'(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    serial_in = b;
    sample_en = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      sample_en = 1'b0;
      serial_in = 1'($urandom);
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  // s[i] is the i-th data bit on the wire; ends one cycle after the stop strobe.
  task automatic apply_stimulus(input logic [3:0] s, input logic par, input logic stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(s[i], gap);
    send_bit(par, gap);
    send_bit(stop, 0);
    @(negedge clk);
    sample_en = 1'b0;
    serial_in = 1'b1;
    #1;
    if (stop) begin
      m_data_lsb = assemble(s, 1'b0);
      m_data_msb = assemble(s, 1'b1);
      m_par      = par;
      m_cnt      = (m_cnt + 1) % 256;
      m_valid++;
    end else begin
      m_err++;
    end
  endtask

  task automatic check_pulse(input string tag, input logic ev, input logic ee);
    check_output({tag, "_valid_lsb"}, valid_lsb, ev);
    check_output({tag, "_valid_msb"}, valid_msb, ev);
    check_output({tag, "_err_lsb"}, err_lsb, ee);
    check_output({tag, "_err_msb"}, err_msb, ee);
  endtask

  task automatic check_model(input string tag);
    repeat (2) @(negedge clk);
    #1;
    check_output({tag, "_data_lsb"}, data_lsb, m_data_lsb);
    check_output({tag, "_data_msb"}, data_msb, m_data_msb);
    check_output({tag, "_par_lsb"}, par_lsb, m_par);
    check_output({tag, "_par_msb"}, par_msb, m_par);
    check_output({tag, "_cnt_lsb"}, cnt_lsb, 32'(m_cnt));
    check_output({tag, "_cnt_msb"}, cnt_msb, 32'(m_cnt));
    check_output({tag, "_busy_lsb"}, busy_lsb, 0);
    check_output({tag, "_busy_msb"}, busy_msb, 0);
    check_output({tag, "_nvalid_lsb"}, valid_seen_lsb, m_valid);
    check_output({tag, "_nvalid_msb"}, valid_seen_msb, m_valid);
    check_output({tag, "_nerr_lsb"}, err_seen_lsb, m_err);
    check_output({tag, "_nerr_msb"}, err_seen_msb, m_err);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    sample_en = 1'b0;
    serial_in = 1'b1;
    #1;
    check_output({tag, "_rst_data"}, {data_msb, data_lsb}, 0);
    check_output({tag, "_rst_par"}, {par_msb, par_lsb}, 0);
    check_output({tag, "_rst_pulse"}, {valid_msb, valid_lsb, err_msb, err_lsb}, 0);
    check_output({tag, "_rst_busy"}, {busy_msb, busy_lsb}, 0);
    check_output({tag, "_rst_cnt"}, {cnt_msb, cnt_lsb}, 0);
    m_data_lsb = '0;
    m_data_msb = '0;
    m_par      = 1'b0;
    m_cnt      = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] s;
    logic       par;
    logic       stop;
    int         gap;
    string      tag;

    rows[0] = '{7'b0101111, 0, 1'b1, 1'b0, 4'hD, 1'b1, 8'd1};
    rows[1] = '{7'b0101110, 0, 1'b0, 1'b1, 4'hD, 1'b1, 8'd1};
    rows[2] = '{7'b0101111, 3, 1'b1, 1'b0, 4'hD, 1'b1, 8'd2};
    rows[3] = '{7'b0010001, 0, 1'b1, 1'b0, 4'h2, 1'b0, 8'd3};
    rows[4] = '{7'b0111101, 1, 1'b1, 1'b0, 4'hF, 1'b0, 8'd4};
    rows[5] = '{7'b0000110, 2, 1'b0, 1'b1, 4'hF, 1'b0, 8'd4};

    do_reset("init");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) s[i] = rows[r].bits[5 - i];
      tag = $sformatf("row%0d", r);
      apply_stimulus(s, rows[r].bits[1], rows[r].bits[0], rows[r].gap);
      check_pulse(tag, rows[r].exp_valid, rows[r].exp_err);
      check_model(tag);
      check_output({tag, "_tbl_data"}, data_lsb, rows[r].exp_data);
      check_output({tag, "_tbl_par"}, par_lsb, rows[r].exp_par);
      check_output({tag, "_tbl_cnt"}, cnt_lsb, rows[r].exp_cnt);
    end

    // Reset in the middle of a frame, then a clean 4'h3 frame.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    sample_en = 1'b0;
    #1;
    check_output("midframe_busy", {busy_msb, busy_lsb}, 2'b11);
    do_reset("midframe");
    apply_stimulus(4'b0011, 1'b0, 1'b1, 0);
    check_pulse("after_rst", 1'b1, 1'b0);
    check_model("after_rst");
    check_output("after_rst_data_lsb", data_lsb, 4'h3);
    check_output("after_rst_data_msb", data_msb, 4'hC);
    check_output("after_rst_cnt", cnt_lsb, 1);

    for (int f = 0; f < 120; f++) begin
      repeat ($urandom_range(0, 2)) send_bit(1'b1, $urandom_range(0, 3));
      s    = 4'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 3);
      tag  = $sformatf("rnd%0d", f);
      apply_stimulus(s, par, stop, gap);
      check_pulse(tag, stop, !stop);
      check_model(tag);
    end

    do_reset("wrap");
    for (int f = 0; f < 256; f++) begin
      apply_stimulus(4'($urandom), 1'($urandom), 1'b1, 0);
      if (f == 254) check_output("cnt_255", cnt_lsb, 255);
    end
    check_model("wrap");
    check_output("wrap_cnt_zero", {cnt_msb, cnt_lsb}, 0);

    apply_stimulus(4'b0011, 1'b1, 1'b1, 0);
    check_model("msb_first");
    check_output("msb_first_data", data_msb, 4'hC);
    check_output("msb_first_par", par_msb, 1);

    check_output("no_overlap", overlap_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0: 0 means the data bits arrive LSB first, 1 means MSB first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port serial_in, input, 1 bit: the serial line; it idles high.
REQ-005 The block SHALL have port sample_en, input, 1 bit: a one-clk strobe at each mid-bit sample point; serial_in is sampled only when it is high.
REQ-006 The block SHALL have port data_out, output, 4 bits: data of the last good frame (bit 0 = a, bit 3 = d for the downstream checker).
REQ-007 The block SHALL have port par_out, output, 1 bit: parity bit of the last good frame (p for the downstream checker).
REQ-008 The block SHALL have port frame_valid, output, 1 bit: a one-cycle pulse when data_out/par_out update.
REQ-009 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a stop-bit framing error.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port frame_cnt, output, 8 bits: count of good frames, wrapping 255->0.

Function
REQ-012 The frame format SHALL be: start bit (0), 4 data bits, 1 parity bit, stop bit (1); one bit per sample_en strobe.
REQ-013 The FSM SHALL have exactly four states: IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on sample_en with serial_in=0 the FSM SHALL go to DATA and clear bit_cnt; on sample_en with serial_in=1 it SHALL stay in IDLE.
REQ-015 DATA: on each sample_en the FSM SHALL store serial_in into shift position bit_cnt, honouring MSB_FIRST.
REQ-016 DATA: bit_cnt SHALL increment on each sample_en; after the sample taken at bit_cnt=3 the FSM SHALL go to PARITY.
REQ-017 PARITY: on sample_en the FSM SHALL capture serial_in as the parity bit and go to STOP.
REQ-018 STOP with sample_en and serial_in=1: data_out and par_out SHALL load the captured values, frame_valid SHALL go high for the next single cycle, frame_cnt SHALL increment, and the FSM SHALL go to IDLE.
REQ-019 STOP with sample_en and serial_in=0: frame_err SHALL go high for the next single cycle, data_out/par_out/frame_cnt SHALL be unchanged, and the FSM SHALL go to IDLE.
REQ-020 In every state, with sample_en low, the state, bit_cnt and all outputs except the pulses SHALL hold; frame_valid and frame_err SHALL be 0.
REQ-021 All outputs SHALL be registered, with no combinational path from serial_in to any output.
REQ-022 The latency from the STOP sample edge to frame_valid SHALL be 1 clk.
REQ-023 The block SHALL NOT compute or check parity; par_out SHALL be passed through unmodified.
REQ-024 A start bit SHALL be accepted only in IDLE, so a 0 seen in STOP is a framing error and not a new start.
REQ-025 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-026 While rst_n=0 the state SHALL be IDLE, bit_cnt SHALL be 0, and data_out, par_out, frame_valid, frame_err, busy and frame_cnt SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no pulse; after release the block SHALL wait for a new start bit.

Structure
REQ-028 Package parity_frame_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP), DATA_W=4 and CNT_W=8.
REQ-029 A single sub-module, frame_shift_reg, SHALL hold the 4-bit capture register with its MSB_FIRST-dependent insert logic; the FSM and counters SHALL stay in the top level.

Verification
REQ-030 Scenario: LSB-first frame 0,1,0,1,1,1,1 -> data_out=4'hD, par_out=1, one frame_valid pulse, frame_cnt=1.
REQ-031 Scenario: same frame with stop=0 -> frame_err for one cycle, data_out keeps its prior value, frame_cnt unchanged, busy=0 afterwards.
REQ-032 Scenario: 3 idle clocks between each strobe -> same result as back-to-back strobes, with no extra pulses.
REQ-033 Scenario: rst_n low after 2 data bits, then a full 4'h3 frame -> data_out=4'h3, exactly one frame_valid pulse, frame_cnt=1.
REQ-034 Scenario: 256 good frames -> frame_cnt wraps to 0; with MSB_FIRST=1, bits 1,1,0,0 -> data_out=4'hC.
